cpu_clk_ctrl: RTL and testbench

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 27 ++
 rtl/cpu_clk_ctrl.sv | 101 ++++++++++
 tb/tb_cpu_clk_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock-enable controller: mode encodings and step FSM states.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        MODE_HALT = 2'b00,
        MODE_RUN  = 2'b01,
        MODE_STEP = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_STEPPING = 2'b01,
        ST_DONE     = 2'b10
    } state_e;

endpackage

// File: rtl/clk_div_chan.sv
// One clock-enable channel: counts enabled cycles and strobes once every div+1 of them.
module clk_div_chan #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic [DIV_W-1:0] div,
    output logic             ce
);

    logic [DIV_W-1:0] cnt;

    // A divider lowered below cnt lets cnt run up to all-ones and wrap silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (run_en) begin
            ce  <= (cnt == div);
            cnt <= (cnt == div) ? '0 : cnt + 1'b1;
        end else begin
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable controller: free-running RUN mode or counted STEP bursts,
// feeding NCH divided enable channels and an enabled-cycle counter.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DIV_W  = 8,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode_i,
    input  logic                 step_req_i,
    input  logic [STEP_W-1:0]    step_cnt_i,
    input  logic [NCH*DIV_W-1:0] div_i,
    output logic [NCH-1:0]       ce_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     cycle_cnt_o
);

    state_e            state_q, state_n;
    logic [STEP_W-1:0] rem_q, rem_n;
    logic              is_run, is_step, run_en;

    assign is_run  = (mode_i == MODE_RUN);
    assign is_step = (mode_i == MODE_STEP);

    // Leaving STEP mid-burst makes the aborting edge a non-enabled cycle, even if the new mode is RUN.
    assign run_en = (state_q == ST_STEPPING) ? is_step : is_run;

    assign busy_o = (state_q == ST_STEPPING);
    assign done_o = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_n;
            rem_q   <= rem_n;
        end
    end

    always_comb begin
        state_n = state_q;
        rem_n   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (is_step && step_req_i) begin
                    if (step_cnt_i != '0) begin
                        state_n = ST_STEPPING;
                        rem_n   = step_cnt_i;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_STEPPING: begin
                if (!is_step) begin
                    state_n = ST_IDLE;
                    rem_n   = '0;
                end else begin
                    rem_n = rem_q - 1'b1;
                    if (rem_q == STEP_W'(1)) begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                rem_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_o <= '0;
        end else if (run_en) begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        clk_div_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .run_en(run_en),
            .div   (div_i[k*DIV_W +: DIV_W]),
            .ce    (ce_o[k])
        );
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with a 4-bit cycle counter so wrap-around is reachable quickly.
module tb_cpu_clk_ctrl;

    localparam int NCH    = 2;
    localparam int DIV_W  = 8;
    localparam int STEP_W = 16;
    localparam int CNT_W  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           mode_i;
    logic                 step_req_i;
    logic [STEP_W-1:0]    step_cnt_i;
    logic [NCH*DIV_W-1:0] div_i;
    logic [NCH-1:0]       ce_o;
    logic                 busy_o;
    logic                 done_o;
    logic [CNT_W-1:0]     cycle_cnt_o;

    int checks = 0;
    int errors = 0;
    int ce0Hits, ce1Hits, busyHits, doneHits;

    cpu_clk_ctrl #(
        .NCH(NCH), .DIV_W(DIV_W), .STEP_W(STEP_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_i     (mode_i),
        .step_req_i (step_req_i),
        .step_cnt_i (step_cnt_i),
        .div_i      (div_i),
        .ce_o       (ce_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cycle_cnt_o(cycle_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] m, input logic r,
                                 input logic [15:0] sc, input logic [7:0] d0, input logic [7:0] d1);
        mode_i     = m;
        step_req_i = r;
        step_cnt_i = sc;
        div_i      = {d1, d0};
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Outputs are sampled on the falling edge, half a period after the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(2'b00, 1'b0, 16'd0, 8'd0, 8'd0);
        tick();
        tick();
        checkOutput("reset_ce",   32'(ce_o), 0);
        checkOutput("reset_busy", 32'(busy_o), 0);
        checkOutput("reset_done", 32'(done_o), 0);
        checkOutput("reset_cyc",  32'(cycle_cnt_o), 0);
        rst_n = 1'b1;

        $display("[TB] RUN with all dividers 0");
        applyStimulus(2'b01, 1'b0, 16'd0, 8'd0, 8'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("run_div0_ce_%0d", i), 32'(ce_o), 3);
        end
        checkOutput("run_div0_cyc", 32'(cycle_cnt_o), 10);

        $display("[TB] RUN with div0=3 div1=0");
        applyStimulus(2'b01, 1'b0, 16'd0, 8'd3, 8'd0);
        ce0Hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput($sformatf("run_div3_ce0_%0d", i), 32'(ce_o[0]), 32'((i % 4) == 3));
            checkOutput($sformatf("run_div3_ce1_%0d", i), 32'(ce_o[1]), 1);
            ce0Hits += int'(ce_o[0]);
        end
        checkOutput("run_div3_ce0_total", 32'(ce0Hits), 3);
        checkOutput("run_div3_cyc", 32'(cycle_cnt_o), 6);

        applyStimulus(2'b11, 1'b0, 16'd0, 8'd3, 8'd0);
        tick();
        checkOutput("mode11_ce",  32'(ce_o), 0);
        checkOutput("mode11_cyc", 32'(cycle_cnt_o), 6);

        $display("[TB] STEP burst of 5");
        applyStimulus(2'b10, 1'b1, 16'd5, 8'd3, 8'd0);
        tick();
        step_req_i = 1'b0;
        checkOutput("step5_busy_first", 32'(busy_o), 1);
        checkOutput("step5_ce_first", 32'(ce_o), 0);
        busyHits = 1; doneHits = 0; ce0Hits = 0; ce1Hits = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            busyHits += int'(busy_o);
            doneHits += int'(done_o);
            ce0Hits  += int'(ce_o[0]);
            ce1Hits  += int'(ce_o[1]);
            if (i == 4) checkOutput("step5_done_at_end", 32'(done_o), 1);
        end
        checkOutput("step5_busy_cycles", 32'(busyHits), 5);
        checkOutput("step5_done_pulses", 32'(doneHits), 1);
        checkOutput("step5_ce1_count", 32'(ce1Hits), 5);
        checkOutput("step5_ce0_count", 32'(ce0Hits), 1);
        checkOutput("step5_cyc", 32'(cycle_cnt_o), 11);

        $display("[TB] STEP burst of 0");
        applyStimulus(2'b10, 1'b1, 16'd0, 8'd3, 8'd0);
        tick();
        step_req_i = 1'b0;
        checkOutput("step0_done", 32'(done_o), 1);
        checkOutput("step0_busy", 32'(busy_o), 0);
        checkOutput("step0_ce", 32'(ce_o), 0);
        tick();
        checkOutput("step0_done_clear", 32'(done_o), 0);
        checkOutput("step0_ce_after", 32'(ce_o), 0);
        checkOutput("step0_cyc", 32'(cycle_cnt_o), 11);

        $display("[TB] STEP burst of 8 aborted after 3");
        applyStimulus(2'b10, 1'b1, 16'd8, 8'd3, 8'd0);
        tick();
        checkOutput("abort_busy_start", 32'(busy_o), 1);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("abort_busy_held_req", 32'(busy_o), 1);
        checkOutput("abort_cyc_before", 32'(cycle_cnt_o), 14);
        mode_i = 2'b00;
        tick();
        checkOutput("abort_busy", 32'(busy_o), 0);
        checkOutput("abort_done", 32'(done_o), 0);
        checkOutput("abort_ce", 32'(ce_o), 0);
        checkOutput("abort_cyc", 32'(cycle_cnt_o), 14);
        tick();
        checkOutput("abort_no_done_later", 32'(done_o), 0);

        $display("[TB] held request re-triggers only after IDLE");
        applyStimulus(2'b10, 1'b1, 16'd2, 8'd3, 8'd0);
        tick();
        checkOutput("held_busy_a", 32'(busy_o), 1);
        tick();
        checkOutput("held_busy_b", 32'(busy_o), 1);
        tick();
        checkOutput("held_busy_c", 32'(busy_o), 0);
        checkOutput("held_done_c", 32'(done_o), 1);
        tick();
        checkOutput("held_done_d", 32'(done_o), 0);
        checkOutput("held_busy_d", 32'(busy_o), 0);
        tick();
        checkOutput("held_retrigger", 32'(busy_o), 1);
        applyStimulus(2'b00, 1'b0, 16'd2, 8'd3, 8'd0);
        tick();
        checkOutput("held_abort_busy", 32'(busy_o), 0);
        checkOutput("held_cyc_wrap", 32'(cycle_cnt_o), 0);

        $display("[TB] reset in the middle of a burst");
        applyStimulus(2'b10, 1'b1, 16'd20, 8'd3, 8'd0);
        tick();
        step_req_i = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        checkOutput("midrst_cyc_before", 32'(cycle_cnt_o), 15);
        checkOutput("midrst_busy_before", 32'(busy_o), 1);
        checkOutput("midrst_ce1_before", 32'(ce_o[1]), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_ce", 32'(ce_o), 0);
        checkOutput("midrst_busy", 32'(busy_o), 0);
        checkOutput("midrst_done", 32'(done_o), 0);
        checkOutput("midrst_cyc", 32'(cycle_cnt_o), 0);
        @(negedge clk);
        applyStimulus(2'b00, 1'b0, 16'd0, 8'd3, 8'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("postrst_no_done", 32'(done_o), 0);

        $display("[TB] first enabled edge after reset");
        applyStimulus(2'b01, 1'b0, 16'd0, 8'd3, 8'd0);
        tick();
        checkOutput("postrst_first_ce", 32'(ce_o), 2);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("postrst_fourth_ce", 32'(ce_o), 3);

        $display("[TB] RUN wrap of cycle counter");
        applyStimulus(2'b01, 1'b0, 16'd0, 8'd0, 8'd0);
        for (int i = 0; i < 11; i++) tick();
        checkOutput("wrap_cyc_15", 32'(cycle_cnt_o), 15);
        tick();
        checkOutput("wrap_cyc_0", 32'(cycle_cnt_o), 0);

        $display("[TB] divider lowered below counter");
        applyStimulus(2'b01, 1'b0, 16'd0, 8'd5, 8'd0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("lower_ce0_before", 32'(ce_o[0]), 0);
        div_i[7:0] = 8'd2;
        ce0Hits = 0;
        for (int i = 0; i < 254; i++) begin
            tick();
            ce0Hits += int'(ce_o[0]);
        end
        checkOutput("lower_no_strobe_wrap", 32'(ce0Hits), 0);
        tick();
        checkOutput("lower_first_strobe", 32'(ce_o[0]), 1);
        tick();
        checkOutput("lower_after_strobe", 32'(ce_o[0]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
